// File: rtl/nrf24_pkg.sv
// rtl/nrf24_pkg.sv - shared types and constants for the nRF24 SPI transaction sequencer
package nrf24_pkg;

  // Sequencer states, in transaction order
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_CMD_WAIT,
    ST_FETCH,
    ST_DATA,
    ST_DATA_WAIT,
    ST_RELEASE,
    ST_GAP
  } state_e;

  // nRF24L01 command bytes (register commands carry the address in the low bits)
  localparam logic [7:0] R_REGISTER   = 8'h00;
  localparam logic [7:0] W_REGISTER   = 8'h20;
  localparam logic [7:0] R_RX_PAYLOAD = 8'h61;
  localparam logic [7:0] W_TX_PAYLOAD = 8'hA0;
  localparam logic [7:0] FLUSH_TX     = 8'hE1;
  localparam logic [7:0] NOP          = 8'hFF;

  // Largest payload the radio accepts in one transaction
  localparam int NRF_MAX_PAYLOAD = 32;

  // True when a requested data length fits in one transaction
  function automatic logic len_ok(input logic [5:0] len, input int unsigned max_len);
    return ({26'b0, len} <= max_len);
  endfunction

endpackage

// File: rtl/nrf24_spi_txn_ctrl.sv
// rtl/nrf24_spi_txn_ctrl.sv - sequences one nRF24 command plus data bytes over a byte-level SPI master
module nrf24_spi_txn_ctrl
  import nrf24_pkg::*;
#(
  parameter int         MAX_LEN    = NRF_MAX_PAYLOAD,
  parameter logic [7:0] DUMMY_BYTE = 8'hFF,
  parameter int         GAP_CYCLES = 10
) (
  input  logic       clk_i,
  input  logic       rst_i,
  // request
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [7:0] req_cmd_i,
  input  logic [5:0] req_len_i,
  input  logic       req_wr_i,
  // write data stream
  input  logic [7:0] wr_data_i,
  input  logic       wr_valid_i,
  output logic       wr_ready_o,
  // read-back stream and status
  output logic [7:0] rd_data_o,
  output logic       rd_valid_o,
  output logic [7:0] status_o,
  output logic       status_valid_o,
  output logic       txn_done_o,
  output logic       err_len_o,
  output logic       busy_o,
  // byte-level SPI master
  output logic       spi_start_o,
  output logic [7:0] spi_tx_byte_o,
  input  logic [7:0] spi_rx_byte_i,
  input  logic       spi_done_i,
  input  logic       spi_busy_i,
  output logic       spi_hold_csn_o
);

  // Gap counter only needs to hold GAP_CYCLES-1
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  state_e          state_q;
  logic [7:0]      cmd_q;
  logic            wr_q;
  logic [5:0]      remaining_q;
  logic [7:0]      data_q;
  logic [GW-1:0]   gap_q;

  logic            req_ready_q;
  logic            wr_ready_q;
  logic [7:0]      rd_data_q;
  logic            rd_valid_q;
  logic [7:0]      status_q;
  logic            status_valid_q;
  logic            txn_done_q;
  logic            err_len_q;
  logic            spi_start_q;
  logic [7:0]      spi_tx_byte_q;
  logic            spi_hold_csn_q;

  // Transaction sequencer: all outputs are registered; pulses default low every cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      cmd_q          <= '0;
      wr_q           <= 1'b0;
      remaining_q    <= '0;
      data_q         <= '0;
      gap_q          <= '0;
      req_ready_q    <= 1'b0;
      wr_ready_q     <= 1'b0;
      rd_data_q      <= '0;
      rd_valid_q     <= 1'b0;
      status_q       <= '0;
      status_valid_q <= 1'b0;
      txn_done_q     <= 1'b0;
      err_len_q      <= 1'b0;
      spi_start_q    <= 1'b0;
      spi_tx_byte_q  <= '0;
      spi_hold_csn_q <= 1'b0;
    end else begin
      spi_start_q    <= 1'b0;
      status_valid_q <= 1'b0;
      rd_valid_q     <= 1'b0;
      txn_done_q     <= 1'b0;
      err_len_q      <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_ready_q && req_valid_i) begin
            if (!len_ok(req_len_i, MAX_LEN)) begin
              // Oversized request is refused without touching the bus
              err_len_q <= 1'b1;
            end else begin
              cmd_q          <= req_cmd_i;
              remaining_q    <= req_len_i;
              wr_q           <= req_wr_i;
              spi_hold_csn_q <= 1'b1;
              req_ready_q    <= 1'b0;
              state_q        <= ST_CMD;
            end
          end
        end

        ST_CMD: begin
          if (!spi_busy_i) begin
            spi_tx_byte_q <= cmd_q;
            spi_start_q   <= 1'b1;
            state_q       <= ST_CMD_WAIT;
          end
        end

        ST_CMD_WAIT: begin
          if (spi_done_i) begin
            // The radio clocks STATUS out while it receives the command byte
            status_q       <= spi_rx_byte_i;
            status_valid_q <= 1'b1;
            if (remaining_q == '0) begin
              state_q <= ST_RELEASE;
            end else begin
              wr_ready_q <= wr_q;
              state_q    <= ST_FETCH;
            end
          end
        end

        ST_FETCH: begin
          if (!wr_q) begin
            data_q  <= DUMMY_BYTE;
            state_q <= ST_DATA;
          end else if (wr_ready_q && wr_valid_i) begin
            // Producer may stall indefinitely here; CSN stays held meanwhile
            data_q     <= wr_data_i;
            wr_ready_q <= 1'b0;
            state_q    <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (!spi_busy_i) begin
            spi_tx_byte_q <= data_q;
            spi_start_q   <= 1'b1;
            state_q       <= ST_DATA_WAIT;
          end
        end

        ST_DATA_WAIT: begin
          if (spi_done_i) begin
            remaining_q <= remaining_q - 6'd1;
            if (!wr_q) begin
              rd_data_q  <= spi_rx_byte_i;
              rd_valid_q <= 1'b1;
            end
            if (remaining_q == 6'd1) begin
              state_q <= ST_RELEASE;
            end else begin
              wr_ready_q <= wr_q;
              state_q    <= ST_FETCH;
            end
          end
        end

        ST_RELEASE: begin
          // Master raises CSN on its own once it has returned to idle
          spi_hold_csn_q <= 1'b0;
          txn_done_q     <= 1'b1;
          if (GAP_CYCLES == 0) begin
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            gap_q   <= GAP_LOAD;
            state_q <= ST_GAP;
          end
        end

        ST_GAP: begin
          if (gap_q == '0) begin
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            gap_q <= gap_q - GW'(1);
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o    = req_ready_q;
  assign wr_ready_o     = wr_ready_q;
  assign rd_data_o      = rd_data_q;
  assign rd_valid_o     = rd_valid_q;
  assign status_o       = status_q;
  assign status_valid_o = status_valid_q;
  assign txn_done_o     = txn_done_q;
  assign err_len_o      = err_len_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign spi_start_o    = spi_start_q;
  assign spi_tx_byte_o  = spi_tx_byte_q;
  assign spi_hold_csn_o = spi_hold_csn_q;

endmodule

// File: tb/tb_nrf24_spi_txn_ctrl.sv
// tb/tb_nrf24_spi_txn_ctrl.sv - self-checking bench with behavioural SPI master and radio responder
module tb_nrf24_spi_txn_ctrl;
  import nrf24_pkg::*;

  localparam int         DIV   = 2;
  localparam int         GAP   = 10;
  localparam logic [7:0] DUMMY = 8'hFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_i;
  logic       req_valid_i, req_ready_o, req_wr_i;
  logic [7:0] req_cmd_i;
  logic [5:0] req_len_i;
  logic [7:0] wr_data_i;
  logic       wr_valid_i, wr_ready_o;
  logic [7:0] rd_data_o, status_o, spi_tx_byte_o, spi_rx_byte_i;
  logic       rd_valid_o, status_valid_o, txn_done_o, err_len_o, busy_o;
  logic       spi_start_o, spi_done_i, spi_busy_i, spi_hold_csn_o;

  nrf24_spi_txn_ctrl #(.MAX_LEN(32), .DUMMY_BYTE(DUMMY), .GAP_CYCLES(GAP)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_cmd_i(req_cmd_i),
    .req_len_i(req_len_i), .req_wr_i(req_wr_i),
    .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .status_o(status_o), .status_valid_o(status_valid_o),
    .txn_done_o(txn_done_o), .err_len_o(err_len_o), .busy_o(busy_o),
    .spi_start_o(spi_start_o), .spi_tx_byte_o(spi_tx_byte_o), .spi_rx_byte_i(spi_rx_byte_i),
    .spi_done_i(spi_done_i), .spi_busy_i(spi_busy_i), .spi_hold_csn_o(spi_hold_csn_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] resp_q[$], wq[$], mosi_got[$], rd_got[$], stat_got[$], tb_data[$];
  logic [7:0] tb_stat, cur_tx, mosi_sh, rxb;
  logic       csn = 1'b1, sclk = 1'b0, mosi = 1'b0;
  bit         chk_en = 1'b1;
  int start_cnt, first_start_cyc, done_cnt, done_cyc, wr_rdy_cyc, err_cnt, viol;
  int csn_falls, sclk_cnt, sclk_in_fetch, bitc, wr_popped, stall_left, gap_from_prev;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor
  initial forever begin
    @(negedge clk);
    if (spi_start_o) begin
      if (start_cnt == 0) first_start_cyc = cyc;
      start_cnt++;
    end
    if (status_valid_o) stat_got.push_back(status_o);
    if (rd_valid_o) rd_got.push_back(rd_data_o);
    if (txn_done_o) begin done_cnt++; done_cyc = cyc; end
    if (wr_ready_o) wr_rdy_cyc++;
    if (err_len_o) err_cnt++;
  end

  // MOSI reconstruction from the serial bus
  initial forever begin
    @(posedge sclk);
    if (!csn) begin
      mosi_sh = {mosi_sh[6:0], mosi};
      bitc++;
      sclk_cnt++;
      if (wr_ready_o) sclk_in_fetch++;
      if (bitc == 8) begin mosi_got.push_back(mosi_sh); bitc = 0; end
    end
  end

  initial forever begin
    @(negedge csn);
    csn_falls++;
    bitc = 0;
    sclk_cnt = 0;
  end

  // SPI master model: waits n cycles and flags protocol violations meanwhile
  task automatic mwait(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (spi_start_o) viol++;
      if (chk_en && spi_tx_byte_o !== cur_tx) viol++;
    end
  endtask

  initial begin
    spi_busy_i = 1'b0; spi_done_i = 1'b0; spi_rx_byte_i = 8'h00;
    forever begin
      @(negedge clk);
      if (!spi_hold_csn_o) csn = 1'b1;
      if (spi_start_o) begin
        cur_tx = spi_tx_byte_o;
        rxb = (resp_q.size() > 0) ? resp_q.pop_front() : 8'h00;
        spi_busy_i = 1'b1;
        csn = 1'b0;
        for (int b = 7; b >= 0; b--) begin
          mosi = cur_tx[b];
          mwait(DIV); sclk = 1'b1;
          mwait(DIV); sclk = 1'b0;
        end
        spi_rx_byte_i = rxb;
        spi_done_i = 1'b1;
        mwait(1);
        spi_done_i = 1'b0;
        spi_busy_i = 1'b0;
      end
    end
  end

  // Write-stream producer with an optional stall before the second byte
  initial begin
    wr_valid_i = 1'b0; wr_data_i = 8'h00;
    forever begin
      @(negedge clk);
      if (wr_popped == 1 && stall_left > 0) begin
        wr_valid_i = 1'b0;
        if (wr_ready_o) stall_left--;
      end else if (wq.size() > 0) begin
        wr_valid_i = 1'b1;
        wr_data_i = wq[0];
      end else begin
        wr_valid_i = 1'b0;
      end
      if (wr_valid_i && wr_ready_o) begin
        void'(wq.pop_front());
        wr_popped++;
      end
    end
  end

  task automatic clear_obs();
    mosi_got.delete(); rd_got.delete(); stat_got.delete();
    start_cnt = 0; done_cnt = 0; wr_rdy_cyc = 0; err_cnt = 0; viol = 0;
    csn_falls = 0; sclk_cnt = 0; sclk_in_fetch = 0; bitc = 0; wr_popped = 0;
  endtask

  task automatic wait_ready(input string tag);
    int t = 0;
    while (!req_ready_o && t < 300) begin @(negedge clk); t++; end
    if (!req_ready_o) check_eq({tag, " req_ready timeout"}, 0, 1);
  endtask

  // One transaction; expectations come straight from the command framing rules
  task automatic run_txn(input string tag, input logic [7:0] cmd, input bit wr, input int stall);
    logic [7:0] exp_mosi[$];
    logic [7:0] exp_rd[$];
    int len, t, acc, prev_done;
    len = tb_data.size();
    resp_q.delete(); wq.delete();
    resp_q.push_back(tb_stat);
    exp_mosi.push_back(cmd);
    foreach (tb_data[i]) begin
      if (wr) begin
        wq.push_back(tb_data[i]);
        exp_mosi.push_back(tb_data[i]);
        resp_q.push_back(8'($urandom));
      end else begin
        resp_q.push_back(tb_data[i]);
        exp_rd.push_back(tb_data[i]);
        exp_mosi.push_back(DUMMY);
      end
    end
    prev_done = done_cyc;
    clear_obs();
    stall_left = stall;
    wait_ready(tag);
    req_cmd_i = cmd; req_len_i = 6'(len); req_wr_i = wr; req_valid_i = 1'b1;
    acc = cyc;
    @(negedge clk);
    req_valid_i = 1'b0;
    t = 0;
    while (done_cnt == 0 && t < 20000) begin @(negedge clk); t++; end
    t = 0;
    while (!csn && t < 300) begin @(negedge clk); t++; end
    gap_from_prev = first_start_cyc - prev_done;

    check_eq({tag, " done"}, done_cnt, 1);
    check_eq({tag, " csn_high"}, csn, 1);
    check_eq({tag, " latency"}, first_start_cyc - acc, 2);
    check_eq({tag, " starts"}, start_cnt, 1 + len);
    check_eq({tag, " mosi_cnt"}, mosi_got.size(), exp_mosi.size());
    foreach (exp_mosi[i])
      check_eq($sformatf("%s mosi%0d", tag, i),
               (i < mosi_got.size()) ? {24'h0, mosi_got[i]} : 32'hxxxxxxxx, exp_mosi[i]);
    check_eq({tag, " status_cnt"}, stat_got.size(), 1);
    check_eq({tag, " status"}, status_o, tb_stat);
    check_eq({tag, " rd_cnt"}, rd_got.size(), exp_rd.size());
    foreach (exp_rd[i])
      check_eq($sformatf("%s rd%0d", tag, i),
               (i < rd_got.size()) ? {24'h0, rd_got[i]} : 32'hxxxxxxxx, exp_rd[i]);
    check_eq({tag, " csn_windows"}, csn_falls, 1);
    check_eq({tag, " sclk_cnt"}, sclk_cnt, 8 * (1 + len));
    check_eq({tag, " wr_ready_cycles"}, wr_rdy_cyc, wr ? len + stall : 0);
    check_eq({tag, " sclk_while_fetch"}, sclk_in_fetch, 0);
    check_eq({tag, " protocol_viol"}, viol, 0);
  endtask

  task automatic run_err(input string tag, input logic [5:0] len);
    clear_obs();
    wait_ready(tag);
    req_cmd_i = W_TX_PAYLOAD; req_len_i = len; req_wr_i = 1'b1; req_valid_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
    check_eq({tag, " err_len"}, err_len_o, 1);
    @(negedge clk);
    check_eq({tag, " ready_back"}, req_ready_o, 1);
    check_eq({tag, " err_pulses"}, err_cnt, 1);
    check_eq({tag, " no_start"}, start_cnt, 0);
    check_eq({tag, " busy"}, busy_o, 0);
  endtask

  task automatic rand_data(input int len);
    tb_data.delete();
    for (int i = 0; i < len; i++) tb_data.push_back(8'($urandom));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_i = 1'b1; req_valid_i = 1'b0; req_cmd_i = 8'h00; req_len_i = 6'd0; req_wr_i = 1'b0;
    clear_obs(); stall_left = 0; done_cyc = 0;
    repeat (3) @(negedge clk);
    check_eq("reset ctrl", {req_ready_o, wr_ready_o, rd_valid_o, status_valid_o, txn_done_o,
                            err_len_o, busy_o, spi_start_o, spi_hold_csn_o}, 0);
    check_eq("reset bytes", {rd_data_o, status_o, spi_tx_byte_o}, 0);
    rst_i = 1'b0;

    tb_stat = 8'h0E; tb_data.delete();
    run_txn("nop", NOP, 1'b1, 0);

    tb_stat = 8'h0E; tb_data = '{8'h4C};
    run_txn("wreg", W_REGISTER | 8'h05, 1'b1, 0);

    tb_stat = 8'h0E; tb_data = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_txn("rxpl", R_RX_PAYLOAD, 1'b0, 0);

    run_err("len33", 6'd33);

    tb_stat = 8'h0E; rand_data(3);
    run_txn("stall", W_TX_PAYLOAD, 1'b1, 50);

    // Back-to-back requests must respect the CSN-high gap
    tb_stat = 8'h0E; rand_data(2);
    run_txn("b2b_a", W_TX_PAYLOAD, 1'b1, 0);
    tb_stat = 8'h0F; rand_data(2);
    run_txn("b2b_b", R_REGISTER | 8'h07, 1'b0, 0);
    check_eq("b2b gap", gap_from_prev >= GAP, 1);

    // Reset in the middle of a 4-byte read
    clear_obs();
    resp_q.delete(); resp_q = '{8'h0E, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    wait_ready("rst");
    req_cmd_i = R_RX_PAYLOAD; req_len_i = 6'd4; req_wr_i = 1'b0; req_valid_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
    t = 0;
    while (start_cnt < 3 && t < 2000) begin @(negedge clk); t++; end
    check_eq("rst reached_data", start_cnt, 3);
    repeat (4) @(negedge clk);
    chk_en = 1'b0;
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check_eq("rst ctrl", {req_ready_o, wr_ready_o, rd_valid_o, status_valid_o, txn_done_o,
                          err_len_o, busy_o, spi_start_o, spi_hold_csn_o}, 0);
    check_eq("rst bytes", {rd_data_o, status_o, spi_tx_byte_o}, 0);
    stat_got.delete(); rd_got.delete();
    t = 0;
    while ((!csn || spi_busy_i) && t < 300) begin @(negedge clk); t++; end
    check_eq("rst csn_high", csn, 1);
    check_eq("rst stray_done_status", stat_got.size(), 0);
    check_eq("rst stray_done_rd", rd_got.size(), 0);
    check_eq("rst status_kept", status_o, 0);
    chk_en = 1'b1;
    tb_stat = 8'h0E; tb_data.delete();
    run_txn("rst_nop", NOP, 1'b1, 0);

    // Randomised transactions
    for (int r = 0; r < 8; r++) begin
      logic [7:0] cmd;
      bit         wr;
      cmd = 8'($urandom);
      wr = 1'($urandom_range(0, 1));
      tb_stat = 8'($urandom);
      rand_data($urandom_range(0, 32));
      run_txn($sformatf("rnd%0d", r), cmd, wr, 0);
      if ($urandom_range(0, 2) == 0) run_err($sformatf("rnd_err%0d", r), 6'($urandom_range(33, 63)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nrf24_spi_txn_ctrl.md
Name: nrf24_spi_txn_ctrl

Overview:
Transaction sequencer directly upstream of the byte-level SPI master used for the nRF24L01 radio link. Accepts one command request (command byte plus 0..32 data bytes) and issues it as back-to-back byte transfers, holding CSN low for the whole transaction. Captures the STATUS byte returned with the command and streams read-back bytes to the consumer. Enforces a minimum CSN-high gap between transactions.

Parameters:
MAX_LEN, 32, maximum data bytes per transaction (nRF24 payload limit)
DUMMY_BYTE, 8'hFF, byte shifted out during read data phases
GAP_CYCLES, 10, clk cycles to stay in GAP after releasing hold_csn (0 = skip GAP)

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  synchronous reset, active-high
req_valid  in  1  request strobe
req_ready  out  1  high only in IDLE
req_cmd  in  8  nRF24 command byte
req_len  in  6  number of data bytes after the command, 0..MAX_LEN
req_wr  in  1  1 = data bytes come from the wr stream; 0 = send DUMMY_BYTE and return rx bytes
wr_data  in  8  write data byte
wr_valid  in  1  write data valid
wr_ready  out  1  write data accept
rd_data  out  8  read-back byte
rd_valid  out  1  1-cycle pulse; no backpressure
status  out  8  STATUS byte captured from the command phase
status_valid  out  1  1-cycle pulse
txn_done  out  1  1-cycle pulse when the transaction is released
err_len  out  1  1-cycle pulse when a request is rejected
busy  out  1  high whenever state != IDLE
spi_start  out  1  1-cycle start pulse to the SPI master
spi_tx_byte  out  8  byte to send; held stable from start until spi_done
spi_rx_byte  in  8  received byte, valid with spi_done
spi_done  in  1  byte-complete pulse
spi_busy  in  1  SPI master busy
spi_hold_csn  out  1  1 = keep CSN low between bytes

Behaviour:
- Reset: all outputs 0 (spi_hold_csn=0, spi_tx_byte=0, status=0, rd_data=0). State = IDLE. Length and gap counters are cleared. Reset mid-transaction aborts immediately. Dropping hold_csn lets the master raise CSN once it reaches its IDLE.
- States: IDLE, CMD, CMD_WAIT, FETCH, DATA, DATA_WAIT, RELEASE, GAP.
- IDLE: req_ready=1. On req_valid:
  - if req_len>MAX_LEN: pulse err_len next cycle and stay in IDLE.
  - otherwise latch cmd, len and wr, set spi_hold_csn=1, and go to CMD.
- CMD: when spi_busy==0, drive spi_tx_byte=cmd and spi_start=1 for exactly one cycle, then go to CMD_WAIT. If spi_busy==1, wait in CMD.
- CMD_WAIT: on spi_done, status<=spi_rx_byte and status_valid pulses. Go to RELEASE if len==0, else FETCH.
- FETCH:
  - if wr: wr_ready=1. On wr_valid&&wr_ready, latch wr_data and go to DATA. An unbounded wait is legal; CSN stays held.
  - if !wr: latch DUMMY_BYTE and go to DATA the same cycle; wr_ready stays 0.
- DATA: issue start under the same rule as CMD, then go to DATA_WAIT.
- DATA_WAIT: on spi_done, decrement the remaining count. If !wr, rd_data<=spi_rx_byte and rd_valid pulses. Go to RELEASE when remaining hits 0, else FETCH.
- RELEASE: spi_hold_csn<=0 and txn_done pulses. Go to GAP with the counter loaded to GAP_CYCLES-1, or to IDLE if GAP_CYCLES==0.
- GAP: count down; at 0 go to IDLE. req_ready stays 0 throughout.
- spi_start never asserts while spi_busy=1 or while waiting for spi_done; at most one byte is outstanding.
- A spi_done arriving outside CMD_WAIT/DATA_WAIT is ignored.
- Byte count: 1 + len transfers per transaction. The count register is 6 bits wide; no wrap is possible given the MAX_LEN check.
- Latency: req accept to first spi_start = 2 cycles when spi_busy=0.

Decomposition:
- Package nrf24_pkg holds:
  - state enum
  - command constants: R_REGISTER 8'h00, W_REGISTER 8'h20, R_RX_PAYLOAD 8'h61, W_TX_PAYLOAD 8'hA0, FLUSH_TX 8'hE1, NOP 8'hFF
  - NRF_MAX_PAYLOAD=32
- No sub-module; the gap counter and byte counter stay inline.
- The bench instantiates this block with the SPI master (DIV=2) and a MISO responder model.

Test Plan:
- NOP, len=0; responder STATUS 8'h0E -> one spi_start; status=8'h0E with status_valid; txn_done; CSN low for exactly 8 SCLK.
- W_REGISTER|5 (8'h25), len=1, wr_data=8'h4C -> MOSI bytes 25,4C under a single CSN low; no rd_valid; wr_ready high exactly once.
- R_RX_PAYLOAD, len=4, req_wr=0; responder returns 0E,11,22,33,44 -> MOSI 61,FF,FF,FF,FF; rd_valid x4 with 11,22,33,44 in order; status=0E.
- req_len=33 -> err_len pulse; no spi_start; req_ready back high the next cycle.
- W_TX_PAYLOAD len=3 with wr_valid stalled 50 cycles before byte 2 -> CSN held low throughout; SCLK idle during the stall; bytes sent in order.
- rst asserted during DATA_WAIT of a 4-byte read -> all outputs 0 next cycle; CSN high after the master finishes; a new NOP completes correctly. Back-to-back requests show ≥GAP_CYCLES between txn_done and the next spi_start.
